sr_cell_memory: RTL and testbench
=================================

// Module: sr_cell_memory
// PURPOSE
//  Parametrised memory of DEPTH words x WIDTH bits in which every bit is a clocked SR cell.
//  It is the successor to the single SR latch and is the storage core of the memory project.
//  Words are read or updated through per-bit set/reset masks over a REQ/READY/ACK handshake.
//  Adds a selectable S=R=1 resolution mode and a multi-cycle clear-all sweep.
// PARAMETERS
//  WIDTH          8   bits per word (>=1)
//  DEPTH          16  number of words (>=2; need not be a power of 2)
//  CONFLICT_MODE  0   S=R=1 resolution: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle
//  AW (localparam)    $clog2(DEPTH), address width
// PORTS
//  CLK    in   1      single clock, all state on rising edge
//  RST_N  in   1      reset, synchronous, active-low
//  REQ    in   1      request valid
//  OP     in   2      00 read, 01 SR update, 10 clear-all, 11 reserved
//  ADDR   in   AW     word address
//  S      in   WIDTH  per-bit set mask (update only)
//  R      in   WIDTH  per-bit reset mask (update only)
//  READY  out  1      block can accept a request this cycle
//  ACK    out  1      one-cycle completion pulse
//  ERR    out  1      valid with ACK: request rejected
//  Q      out  WIDTH  registered word result
//  NQ     out  WIDTH  always ~Q
// BEHAVIOUR
//  Reset (RST_N=0 at an edge):
//  - All words 0; Q=0; NQ={WIDTH{1}}; ACK=0; ERR=0; READY=0; FSM=IDLE.
//  - READY=1 from the first edge with RST_N=1.
//  Handshake:
//  - Request is accepted on an edge where REQ=1 and READY=1. REQ while READY=0 is ignored, not queued.
//  - ACK is high exactly one cycle, in the cycle after completion.
//  - ERR is meaningful only while ACK=1; otherwise ERR=0.
//  Read (OP=00):
//  - Latency 1: Q=mem[ADDR] and ACK=1 in the next cycle.
//  - READY stays 1, so reads or updates may issue back-to-back, one per cycle.
//  Update (OP=01): per bit, next = S&~R ? 1 : ~S&R ? 0 : ~S&~R ? old : conflict, where conflict is:
//  - mode 0: old
//  - mode 1: 1
//  - mode 2: 0
//  - mode 3: ~old
//  Update completion:
//  - Next cycle: word written, Q=new word (write-through), ACK=1.
//  - A read of the same address in the following cycle returns the new value (no hazard).
//  Clear-all (OP=10), FSM IDLE->SWEEP->IDLE:
//  - On accept, READY drops to 0 and the sweep zeroes one word per cycle, address 0..DEPTH-1 (DEPTH cycles).
//  - The cycle after the last word is written: ACK=1, Q=0, FSM=IDLE, READY=1.
//  Errors (no state change, Q holds):
//  - OP=11: ACK=1 and ERR=1 next cycle.
//  - ADDR>=DEPTH on read or update: ACK=1 and ERR=1 next cycle.
//  Reset mid-sweep aborts the sweep and no ACK is issued; all words are 0 by the reset itself.
//  Widths: the sweep counter is AW bits; its terminal compare is against DEPTH-1, so there is no wrap past the last word.
// STRUCTURE
//  Shared package sr_mem_pkg holds:
//  - OP_READ/OP_UPDATE/OP_CLEAR/OP_RSVD
//  - CM_HOLD/CM_SET/CM_RESET/CM_TOGGLE
//  - state typedef {IDLE, SWEEP}
//  Sub-module sr_cell_word:
//  - Combinational per-bit next-state function for WIDTH bits under CONFLICT_MODE.
//  - Inputs S, R, old; output next.
//  Top level holds the storage array, the FSM, the sweep counter and the output registers.
// TESTING
//  1. Release reset: Q=00, NQ=FF, READY=1 next cycle; read addr 5 -> Q=00, ACK=1, ERR=0.
//  2. Update addr 3, S=0F, R=00; then update addr 3, S=00, R=03 -> Q=0F then 0C; read addr 3 -> 0C.
//  3. Conflict on word A5 with S=R=FF -> mode 0 A5, mode 1 FF, mode 2 00, mode 3 5A.
//  4. Clear-all after writing FF to all words:
//     READY=0 for 16 cycles, ACK on cycle 17; reads of addr 0 and 15 return 00.
//  5. DEPTH=12: read addr 13 -> ACK=1, ERR=1, Q unchanged. OP=11 -> ACK=1, ERR=1, no word changes.
//  6. Reset mid-sweep (cycle 6), and REQ while READY=0:
//     no ACK; all words 00; the ignored request never produces an ACK.

Source files
------------

// File: rtl/sr_mem_pkg.sv
// Shared definitions for the SR-cell memory: opcodes, conflict-resolution modes
// and the controller state type.
package sr_mem_pkg;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_UPDATE = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  localparam int CM_HOLD   = 0;
  localparam int CM_SET    = 1;
  localparam int CM_RESET  = 2;
  localparam int CM_TOGGLE = 3;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

endpackage

// File: rtl/sr_cell_word.sv
// Combinational next-state of a word of clocked SR cells; the S=R=1 case is
// resolved according to CONFLICT_MODE.
module sr_cell_word
  import sr_mem_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int CONFLICT_MODE = CM_HOLD
) (
  input  logic [WIDTH-1:0] i_s,
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_old,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] w_conflict;

  always_comb begin
    w_conflict = i_old;
    case (CONFLICT_MODE)
      CM_SET:    w_conflict = '1;
      CM_RESET:  w_conflict = '0;
      CM_TOGGLE: w_conflict = ~i_old;
      default:   w_conflict = i_old;
    endcase
  end

  // Set wins alone, hold when idle, conflict value when both asserted; reset-only yields 0.
  assign o_next = (i_s & ~i_r) | (i_old & ~i_s & ~i_r) | (w_conflict & i_s & i_r);

endmodule

// File: rtl/sr_cell_memory.sv
// DEPTH x WIDTH memory of SR cells behind a REQ/READY/ACK handshake, with
// read, masked SR update and a one-word-per-cycle clear-all sweep.
module sr_cell_memory
  import sr_mem_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int CONFLICT_MODE = CM_HOLD,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req,
  input  logic [1:0]       i_op,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_s,
  input  logic [WIDTH-1:0] i_r,
  output logic             o_ready,
  output logic             o_ack,
  output logic             o_err,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_nq
);

  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [AW-1:0]    r_sweep_addr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;
  logic             r_ready;
  logic             r_ack;
  logic             r_err;

  logic             w_accept;
  logic             w_addr_ok;
  logic             w_sweep_last;
  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_next_word;

  // READY is only ever high in IDLE, so an accept implies the controller is idle.
  assign w_accept     = i_req & r_ready;
  assign w_addr_ok    = ({1'b0, i_addr} < DEPTH_W);
  assign w_sweep_last = (r_sweep_addr == LAST_ADDR);
  assign w_old        = w_addr_ok ? r_mem[i_addr] : '0;

  sr_cell_word #(
    .WIDTH        (WIDTH),
    .CONFLICT_MODE(CONFLICT_MODE)
  ) u_word (
    .i_s   (i_s),
    .i_r   (i_r),
    .i_old (w_old),
    .o_next(w_next_word)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept && i_op == OP_CLEAR) w_next_state = SWEEP;
      SWEEP:   if (w_sweep_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Storage, sweep counter and registered outputs; ACK/ERR are single-cycle pulses.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_q          <= '0;
      r_ready      <= 1'b0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_sweep_addr <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            case (i_op)
              OP_READ: begin
                r_ack <= 1'b1;
                if (w_addr_ok) r_q <= w_old;
                else           r_err <= 1'b1;
              end
              OP_UPDATE: begin
                r_ack <= 1'b1;
                if (w_addr_ok) begin
                  r_mem[i_addr] <= w_next_word;
                  r_q           <= w_next_word;
                end else begin
                  r_err <= 1'b1;
                end
              end
              OP_CLEAR: begin
                r_ready      <= 1'b0;
                r_sweep_addr <= '0;
              end
              default: begin
                r_ack <= 1'b1;
                r_err <= 1'b1;
              end
            endcase
          end
        end
        SWEEP: begin
          r_mem[r_sweep_addr] <= '0;
          if (w_sweep_last) begin
            r_ack   <= 1'b1;
            r_q     <= '0;
            r_ready <= 1'b1;
          end else begin
            r_sweep_addr <= r_sweep_addr + 1'b1;
          end
        end
        default: r_ready <= 1'b0;
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_ack   = r_ack;
  assign o_err   = r_err;
  assign o_q     = r_q;
  assign o_nq    = ~r_q;

endmodule

// File: tb/tb_sr_cell_memory.sv
// Directed bench: four instances share one stimulus stream (conflict modes 0-3,
// the mode-3 copy built with DEPTH=12) and are checked against hand values.
module tb_sr_cell_memory;
  import sr_mem_pkg::*;

  logic       clk;
  logic       rstN;
  logic       req;
  logic [1:0] op;
  logic [3:0] addr;
  logic [7:0] sMask;
  logic [7:0] rMask;

  logic       ready [4];
  logic       ack   [4];
  logic       err   [4];
  logic [7:0] q     [4];
  logic [7:0] nq    [4];

  int checkCount = 0;
  int passCount  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sr_cell_memory #(.WIDTH(8), .DEPTH(16), .CONFLICT_MODE(0)) u0 (
    .i_clk(clk), .i_rst_n(rstN), .i_req(req), .i_op(op), .i_addr(addr), .i_s(sMask), .i_r(rMask),
    .o_ready(ready[0]), .o_ack(ack[0]), .o_err(err[0]), .o_q(q[0]), .o_nq(nq[0]));
  sr_cell_memory #(.WIDTH(8), .DEPTH(16), .CONFLICT_MODE(1)) u1 (
    .i_clk(clk), .i_rst_n(rstN), .i_req(req), .i_op(op), .i_addr(addr), .i_s(sMask), .i_r(rMask),
    .o_ready(ready[1]), .o_ack(ack[1]), .o_err(err[1]), .o_q(q[1]), .o_nq(nq[1]));
  sr_cell_memory #(.WIDTH(8), .DEPTH(16), .CONFLICT_MODE(2)) u2 (
    .i_clk(clk), .i_rst_n(rstN), .i_req(req), .i_op(op), .i_addr(addr), .i_s(sMask), .i_r(rMask),
    .o_ready(ready[2]), .o_ack(ack[2]), .o_err(err[2]), .o_q(q[2]), .o_nq(nq[2]));
  sr_cell_memory #(.WIDTH(8), .DEPTH(12), .CONFLICT_MODE(3)) u3 (
    .i_clk(clk), .i_rst_n(rstN), .i_req(req), .i_op(op), .i_addr(addr), .i_s(sMask), .i_r(rMask),
    .o_ready(ready[3]), .o_ack(ack[3]), .o_err(err[3]), .o_q(q[3]), .o_nq(nq[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request; outputs are sampled 1ns after the completing edge.
  task automatic applyStimulus(input logic [1:0] opIn, input logic [3:0] addrIn,
                               input logic [7:0] sIn, input logic [7:0] rIn);
    req   = 1'b1;
    op    = opIn;
    addr  = addrIn;
    sMask = sIn;
    rMask = rIn;
    tick();
    req   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  initial begin
    int cyc;
    int lowCnt;

    rstN = 1'b0; req = 1'b0; op = OP_READ; addr = '0; sMask = '0; rMask = '0;
    tick();
    tick();
    checkOutput("rst_q",     q[0],     32'h00);
    checkOutput("rst_nq",    nq[0],    32'hFF);
    checkOutput("rst_ready", ready[0], 32'h0);
    checkOutput("rst_ack",   ack[0],   32'h0);
    checkOutput("rst_err",   err[0],   32'h0);

    rstN = 1'b1;
    tick();
    checkOutput("rel_ready", ready[0], 32'h1);
    checkOutput("rel_nq",    nq[0],    32'hFF);

    applyStimulus(OP_READ, 4'd5, 8'h00, 8'h00);
    checkOutput("rd5_ack", ack[0], 32'h1);
    checkOutput("rd5_err", err[0], 32'h0);
    checkOutput("rd5_q",   q[0],   32'h00);
    tick();
    checkOutput("ack_pulse", ack[0], 32'h0);

    applyStimulus(OP_UPDATE, 4'd3, 8'h0F, 8'h00);
    checkOutput("upd_set_q",   q[0],   32'h0F);
    checkOutput("upd_set_ack", ack[0], 32'h1);
    applyStimulus(OP_UPDATE, 4'd3, 8'h00, 8'h03);
    checkOutput("upd_rst_q",  q[0],   32'h0C);
    checkOutput("upd_rst_nq", nq[0],  32'hF3);
    checkOutput("b2b_ack",    ack[0], 32'h1);
    applyStimulus(OP_READ, 4'd3, 8'h00, 8'h00);
    checkOutput("rd3_q", q[0], 32'h0C);

    applyStimulus(OP_UPDATE, 4'd7, 8'hA5, 8'h00);
    checkOutput("a5_write", q[3], 32'hA5);
    applyStimulus(OP_UPDATE, 4'd7, 8'hFF, 8'hFF);
    checkOutput("cm_hold",   q[0], 32'hA5);
    checkOutput("cm_set",    q[1], 32'hFF);
    checkOutput("cm_reset",  q[2], 32'h00);
    checkOutput("cm_toggle", q[3], 32'h5A);
    applyStimulus(OP_READ, 4'd7, 8'h00, 8'h00);
    checkOutput("cm_toggle_rd", q[3], 32'h5A);

    for (int a = 0; a < 16; a++) applyStimulus(OP_UPDATE, 4'(a), 8'hFF, 8'h00);
    checkOutput("fill_q15", q[0], 32'hFF);
    checkOutput("fill_oob_err", err[3], 32'h1);

    applyStimulus(OP_CLEAR, 4'd0, 8'h00, 8'h00);
    cyc = 0;
    lowCnt = 0;
    while (cyc < 40) begin
      cyc++;
      if (ready[0] == 1'b0) lowCnt++;
      if (ack[0] == 1'b1) break;
      tick();
    end
    checkOutput("clr_ack_cycle", cyc,      32'd17);
    checkOutput("clr_ready_low", lowCnt,   32'd16);
    checkOutput("clr_ready_end", ready[0], 32'h1);
    checkOutput("clr_q",         q[0],     32'h00);
    checkOutput("clr_err",       err[0],   32'h0);
    applyStimulus(OP_READ, 4'd0, 8'h00, 8'h00);
    checkOutput("clr_rd0", q[0], 32'h00);
    applyStimulus(OP_READ, 4'd15, 8'h00, 8'h00);
    checkOutput("clr_rd15", q[0], 32'h00);
    checkOutput("clr_rd15_ack", ack[0], 32'h1);

    applyStimulus(OP_UPDATE, 4'd2, 8'h3C, 8'h00);
    checkOutput("d12_upd2", q[3], 32'h3C);
    applyStimulus(OP_READ, 4'd13, 8'h00, 8'h00);
    checkOutput("d12_oob_ack", ack[3], 32'h1);
    checkOutput("d12_oob_err", err[3], 32'h1);
    checkOutput("d12_oob_q",   q[3],   32'h3C);
    checkOutput("d16_rd13_err", err[0], 32'h0);
    applyStimulus(OP_RSVD, 4'd2, 8'hFF, 8'h00);
    checkOutput("rsvd_ack", ack[3], 32'h1);
    checkOutput("rsvd_err", err[3], 32'h1);
    checkOutput("rsvd_q",   q[3],   32'h3C);
    checkOutput("rsvd_err16", err[0], 32'h1);
    tick();
    checkOutput("err_idle", err[3], 32'h0);
    applyStimulus(OP_READ, 4'd2, 8'h00, 8'h00);
    checkOutput("rsvd_nochg", q[3], 32'h3C);
    checkOutput("rsvd_nochg16", q[0], 32'h3C);

    applyStimulus(OP_UPDATE, 4'd9, 8'h77, 8'h00);
    checkOutput("pre_sweep_w9", q[0], 32'h77);
    applyStimulus(OP_CLEAR, 4'd0, 8'h00, 8'h00);
    tick();
    applyStimulus(OP_READ, 4'd9, 8'h00, 8'h00);
    checkOutput("ignored_req_ack", ack[0], 32'h0);
    checkOutput("ignored_req_rdy", ready[0], 32'h0);
    tick();
    tick();
    tick();
    rstN = 1'b0;
    tick();
    checkOutput("midrst_ready", ready[0], 32'h0);
    checkOutput("midrst_ack",   ack[0],   32'h0);
    rstN = 1'b1;
    tick();
    checkOutput("midrst_rel_ready", ready[0], 32'h1);
    checkOutput("midrst_rel_ack",   ack[0],   32'h0);
    tick();
    checkOutput("midrst_no_ack", ack[0], 32'h0);
    applyStimulus(OP_READ, 4'd9, 8'h00, 8'h00);
    checkOutput("midrst_rd9",     q[0],   32'h00);
    checkOutput("midrst_rd9_ack", ack[0], 32'h1);
    applyStimulus(OP_READ, 4'd2, 8'h00, 8'h00);
    checkOutput("midrst_rd2", q[0], 32'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
